// File: rtl/cpu_if_decode_mux_pkg.sv
// cpu_if_pkg: shared types for the CPU-interface address decode mux.
//   cpu_addr_t       : word address, bits [31:2]
//   cpu_data_t       : 32-bit data word
//   ERR_DATA_DEFAULT : read data returned on an errored access
//   cpu_if_state_e   : mux FSM states, also exposed as the debug state output
//   sel_width()      : width of a slave-select index (at least 1 bit)
package cpu_if_pkg;

  typedef logic [31:2] cpu_addr_t;
  typedef logic [31:0] cpu_data_t;

  localparam cpu_data_t ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } cpu_if_state_e;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cpu_if_decode_mux_if.sv
// cpu_if_decode_mux_if: bundles the upstream cpu_if port and the N_SLV
// downstream register-bank ports of the decode mux.
//   modport slave  : used by the mux itself (accepts upstream requests,
//                    issues downstream requests)
//   modport master : used by the environment (upstream CPU plus slaves)
//
// Handshake: there is no valid/ready pair. A request is a single-cycle
// read or write pulse with address/data valid in that same cycle; it is
// only taken while h_busy is low, otherwise it is dropped. Every taken
// request is answered by exactly one single-cycle access_complete pulse,
// with read_data and access_error valid in that cycle. Downstream uses the
// same pulse protocol: one s_cpu_if_read/write pulse per access, answered by
// one s_cpu_if_access_complete pulse from the addressed slave.
interface cpu_if_decode_mux_if
  import cpu_if_pkg::*;
#(
  parameter int N_SLV = 4
) ();

  // upstream
  logic               h_cpu_if_read;
  logic               h_cpu_if_write;
  cpu_data_t          h_cpu_if_write_data;
  cpu_addr_t          h_cpu_if_address;
  cpu_data_t          h_cpu_if_read_data;
  logic               h_cpu_if_access_complete;
  logic               h_cpu_if_access_error;
  logic               h_busy;

  // downstream
  logic [N_SLV-1:0]    s_cpu_if_read;
  logic [N_SLV-1:0]    s_cpu_if_write;
  cpu_data_t           s_cpu_if_write_data;
  cpu_addr_t           s_cpu_if_address;
  logic [N_SLV*32-1:0] s_cpu_if_read_data;
  logic [N_SLV-1:0]    s_cpu_if_access_complete;

  modport slave (
    input  h_cpu_if_read, h_cpu_if_write, h_cpu_if_write_data, h_cpu_if_address,
    output h_cpu_if_read_data, h_cpu_if_access_complete, h_cpu_if_access_error, h_busy,
    output s_cpu_if_read, s_cpu_if_write, s_cpu_if_write_data, s_cpu_if_address,
    input  s_cpu_if_read_data, s_cpu_if_access_complete
  );

  modport master (
    output h_cpu_if_read, h_cpu_if_write, h_cpu_if_write_data, h_cpu_if_address,
    input  h_cpu_if_read_data, h_cpu_if_access_complete, h_cpu_if_access_error, h_busy,
    input  s_cpu_if_read, s_cpu_if_write, s_cpu_if_write_data, s_cpu_if_address,
    output s_cpu_if_read_data, s_cpu_if_access_complete
  );

endinterface

// File: rtl/cpu_if_addr_decode.sv
// cpu_if_addr_decode: combinational address decoder.
//   addr : word address to decode
//   hit  : 1 when any slave range matches
//   sel  : index of the matching slave; lowest index wins on overlap
// Slave i matches when (addr & SLV_MASK[i]) == SLV_BASE[i].
module cpu_if_addr_decode
  import cpu_if_pkg::*;
#(
  parameter int                  N_SLV    = 4,
  parameter logic [N_SLV*30-1:0] SLV_BASE = {N_SLV{30'h0}},
  parameter logic [N_SLV*30-1:0] SLV_MASK = {N_SLV{30'h3FFF_FF00}},
  localparam int                 SEL_W    = sel_width(N_SLV)
) (
  input  cpu_addr_t        addr,
  output logic             hit,
  output logic [SEL_W-1:0] sel
);

  // Scan from the top index down so the lowest matching index is the
  // last one written and therefore wins.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if ((addr & SLV_MASK[30*i +: 30]) == SLV_BASE[30*i +: 30]) begin
        hit = 1'b1;
        sel = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/cpu_if_decode_mux.sv
// cpu_if_decode_mux: fans one upstream cpu_if master out to N_SLV
// register-bank slaves, one access at a time.
//   h_clk, h_reset_n : clock, synchronous active-low reset
//   bus              : upstream request/response and downstream slave ports
//   dbg_state        : current FSM state
// Unmapped addresses, simultaneous read+write and slave timeouts complete
// upstream with access_error = 1 and ERR_DATA as read data. All outputs
// are registered.
module cpu_if_decode_mux
  import cpu_if_pkg::*;
#(
  parameter int                  N_SLV    = 4,
  parameter logic [N_SLV*30-1:0] SLV_BASE = {N_SLV{30'h0}},
  parameter logic [N_SLV*30-1:0] SLV_MASK = {N_SLV{30'h3FFF_FF00}},
  parameter int                  TIMEOUT  = 1024,
  parameter cpu_data_t           ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic                       h_clk,
  input  logic                       h_reset_n,
  cpu_if_decode_mux_if.slave         bus,
  output cpu_if_state_e              dbg_state
);

  localparam int SEL_W = sel_width(N_SLV);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0]       state_q, state_d;
  cpu_addr_t        addr_q, addr_d;
  cpu_data_t        wdata_q, wdata_d;
  logic             is_rd_q, is_rd_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_SLV-1:0] s_rd_q, s_rd_d;
  logic [N_SLV-1:0] s_wr_q, s_wr_d;
  logic             comp_q, comp_d;
  logic             aerr_q, aerr_d;
  cpu_data_t        rdata_q, rdata_d;
  logic             busy_q, busy_d;

  logic             dec_hit;
  logic [SEL_W-1:0] dec_sel;
  logic             req_any;
  logic             req_bad;
  logic [N_SLV-1:0] dec_onehot;
  logic [CNT_W-1:0] cnt_inc;
  cpu_data_t        slv_rdata;

  cpu_if_addr_decode #(
    .N_SLV    (N_SLV),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_decode (
    .addr (bus.h_cpu_if_address),
    .hit  (dec_hit),
    .sel  (dec_sel)
  );

  assign req_any    = bus.h_cpu_if_read | bus.h_cpu_if_write;
  assign req_bad    = (bus.h_cpu_if_read & bus.h_cpu_if_write) | ~dec_hit;
  assign dec_onehot = N_SLV'(1) << dec_sel;
  assign cnt_inc    = cnt_q + CNT_W'(1);
  assign slv_rdata  = bus.s_cpu_if_read_data[32*sel_q +: 32];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    is_rd_d = is_rd_q;
    sel_d   = sel_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    s_rd_d  = '0;
    s_wr_d  = '0;
    comp_d  = 1'b0;
    aerr_d  = 1'b0;
    rdata_d = '0;

    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          addr_d  = bus.h_cpu_if_address;
          wdata_d = bus.h_cpu_if_write_data;
          is_rd_d = bus.h_cpu_if_read;
          sel_d   = dec_sel;
          err_d   = req_bad;
          busy_d  = 1'b1;
          state_d = ST_ISSUE;
          // The downstream pulse is registered here so it is visible
          // during the ISSUE cycle.
          if (!req_bad) begin
            if (bus.h_cpu_if_read) s_rd_d = dec_onehot;
            else                   s_wr_d = dec_onehot;
          end
        end
      end

      ST_ISSUE: begin
        cnt_d = '0;
        if (err_q) begin
          state_d = ST_RESP;
          comp_d  = 1'b1;
          aerr_d  = 1'b1;
          rdata_d = ERR_DATA;
        end else begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        cnt_d = cnt_inc;
        // A completion in the last allowed WAIT cycle beats the timeout.
        if (bus.s_cpu_if_access_complete[sel_q]) begin
          state_d = ST_RESP;
          comp_d  = 1'b1;
          rdata_d = is_rd_q ? slv_rdata : '0;
        end else if (cnt_inc == TIMEOUT_CNT) begin
          state_d = ST_RESP;
          comp_d  = 1'b1;
          aerr_d  = 1'b1;
          rdata_d = ERR_DATA;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge h_clk) begin
    if (!h_reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      is_rd_q <= 1'b0;
      sel_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      s_rd_q  <= '0;
      s_wr_q  <= '0;
      comp_q  <= 1'b0;
      aerr_q  <= 1'b0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      is_rd_q <= is_rd_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      s_rd_q  <= s_rd_d;
      s_wr_q  <= s_wr_d;
      comp_q  <= comp_d;
      aerr_q  <= aerr_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.h_cpu_if_read_data       = rdata_q;
  assign bus.h_cpu_if_access_complete = comp_q;
  assign bus.h_cpu_if_access_error    = aerr_q;
  assign bus.h_busy                   = busy_q;
  assign bus.s_cpu_if_read            = s_rd_q;
  assign bus.s_cpu_if_write           = s_wr_q;
  assign bus.s_cpu_if_write_data      = wdata_q;
  assign bus.s_cpu_if_address         = addr_q;

  assign dbg_state = cpu_if_state_e'(state_q);

endmodule
